// File: rtl/sys1_input_pkg.sv
// Shared constants and types for the SEGASYSTEM1 player-input stage:
// PS/2 scancodes, joystick/INP bit positions and the coin FSM state type.
package sys1_input_pkg;

    localparam int unsigned CNT_W = 4;

    // Scancodes matched on the low 8 bits only (extended flag ignored)
    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;
    localparam logic [7:0] SC_P1_TRIG1 = 8'h29;
    localparam logic [7:0] SC_P1_TRIG2 = 8'h14;
    localparam logic [7:0] SC_P1_TRIG3 = 8'h11;
    localparam logic [7:0] SC_F1       = 8'h05;
    localparam logic [7:0] SC_F2       = 8'h06;

    // Scancodes matched on {extended, code}
    localparam logic [8:0] SC_START1   = 9'h016;
    localparam logic [8:0] SC_START2   = 9'h01E;
    localparam logic [8:0] SC_COIN1    = 9'h02E;
    localparam logic [8:0] SC_COIN2    = 9'h036;
    localparam logic [8:0] SC_P2_UP    = 9'h02D;
    localparam logic [8:0] SC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] SC_P2_LEFT  = 9'h023;
    localparam logic [8:0] SC_P2_RIGHT = 9'h034;
    localparam logic [8:0] SC_P2_TRIG1 = 9'h01C;
    localparam logic [8:0] SC_P2_TRIG2 = 9'h01B;
    localparam logic [8:0] SC_P2_TRIG3 = 9'h015;

    localparam int unsigned JOY_R      = 0;
    localparam int unsigned JOY_L      = 1;
    localparam int unsigned JOY_D      = 2;
    localparam int unsigned JOY_U      = 3;
    localparam int unsigned JOY_TRIG1  = 4;
    localparam int unsigned JOY_TRIG2  = 5;
    localparam int unsigned JOY_TRIG3  = 6;
    localparam int unsigned JOY_START1 = 7;
    localparam int unsigned JOY_START2 = 8;
    localparam int unsigned JOY_COIN   = 9;
    localparam int unsigned JOY_USED_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic trig1;
        logic trig2;
        logic trig3;
    } ctl_t;

    function automatic ctl_t joy_ctl(input logic [JOY_USED_W-1:0] j);
        ctl_t c;
        c.up    = j[JOY_U];
        c.down  = j[JOY_D];
        c.left  = j[JOY_L];
        c.right = j[JOY_R];
        c.trig1 = j[JOY_TRIG1];
        c.trig2 = j[JOY_TRIG2];
        c.trig3 = j[JOY_TRIG3];
        return c;
    endfunction

    // Active-low player byte: ~{left,right,up,down,0,trig2,trig1,trig3}
    function automatic logic [7:0] ctl_byte(input ctl_t c);
        return ~{c.left, c.right, c.up, c.down, 1'b0, c.trig2, c.trig1, c.trig3};
    endfunction

endpackage

// File: rtl/sys1_coin_shaper.sv
// Turns coin request strobes into vblank-timed coin pulses with a
// saturating 3-deep pending queue and a forced gap between coins.
module sys1_coin_shaper
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3,
    parameter int unsigned GAP_FRAMES  = 2
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_coin_req,
    input  logic i_vblank,
    output logic o_coin
);

    logic             r_vblank_q;
    logic             w_vbl_rise;
    logic [1:0]       r_queue;
    coin_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_coin;
    logic             w_start;

    assign w_vbl_rise = i_vblank & ~r_vblank_q;
    assign w_start    = (r_state == IDLE) && (r_queue != 2'd0);
    assign o_coin     = r_coin;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q <= 1'b0;
        end else begin
            r_vblank_q <= i_vblank;
        end
    end

    // Pending count: a request and a launch in the same cycle cancel out
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_queue <= 2'd0;
        end else if (i_coin_req && !w_start) begin
            if (r_queue != 2'd3) begin
                r_queue <= r_queue + 2'd1;
            end
        end else if (!i_coin_req && w_start) begin
            r_queue <= r_queue - 2'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_coin  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= PULSE;
                        r_cnt   <= '0;
                        r_coin  <= 1'b1;
                    end
                end
                PULSE: begin
                    if (w_vbl_rise) begin
                        if (r_cnt + CNT_W'(1) == CNT_W'(COIN_FRAMES)) begin
                            r_state <= GAP;
                            r_cnt   <= '0;
                            r_coin  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (w_vbl_rise) begin
                        if (r_cnt + CNT_W'(1) == CNT_W'(GAP_FRAMES)) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_coin  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sys1_input_ctrl.sv
// Player-input conditioning for SEGASYSTEM1: PS/2 key decode merged with
// the HPS joystick words into the core's active-low INP0/INP1/INP2 bytes.
module sys1_input_ctrl
    import sys1_input_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3,
    parameter int unsigned GAP_FRAMES  = 2,
    parameter int unsigned CABINET     = 0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    input  logic        vblank,
    output logic [7:0]  INP0,
    output logic [7:0]  INP1,
    output logic [7:0]  INP2
);

    logic                  r_prev_tog;
    logic                  r_armed;
    logic                  w_event;
    logic                  w_pressed;
    ctl_t                  r_k1;
    ctl_t                  r_k2;
    logic                  r_kstart1;
    logic                  r_kstart2;
    logic                  r_kcoin1;
    logic                  r_kcoin2;
    logic [JOY_USED_W-1:0] r_joy1;
    logic [JOY_USED_W-1:0] r_joy2;
    ctl_t                  w_p1;
    ctl_t                  w_p2;
    logic                  w_start1;
    logic                  w_start2;
    logic                  w_m_coin;
    logic                  r_m_coin_q;
    logic                  w_coin_req;
    logic                  w_coin;
    logic                  w_unused;
    logic [7:0]            r_inp0;
    logic [7:0]            r_inp1;
    logic [7:0]            r_inp2;

    assign w_unused  = ^{joystk1[15:JOY_USED_W], joystk2[15:JOY_USED_W]};
    assign w_event   = r_armed & (ps2_key[10] != r_prev_tog);
    assign w_pressed = ps2_key[9];

    // The first cycle after reset only captures the toggle level
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_tog <= 1'b0;
            r_armed    <= 1'b0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_kstart1  <= 1'b0;
            r_kstart2  <= 1'b0;
            r_kcoin1   <= 1'b0;
            r_kcoin2   <= 1'b0;
        end else begin
            r_prev_tog <= ps2_key[10];
            r_armed    <= 1'b1;
            if (w_event) begin
                case (ps2_key[7:0])
                    SC_P1_UP:    r_k1.up    <= w_pressed;
                    SC_P1_DOWN:  r_k1.down  <= w_pressed;
                    SC_P1_LEFT:  r_k1.left  <= w_pressed;
                    SC_P1_RIGHT: r_k1.right <= w_pressed;
                    SC_P1_TRIG1: r_k1.trig1 <= w_pressed;
                    SC_P1_TRIG2: r_k1.trig2 <= w_pressed;
                    SC_P1_TRIG3: r_k1.trig3 <= w_pressed;
                    SC_F1: begin
                        r_kstart1 <= w_pressed;
                        r_kcoin1  <= w_pressed;
                    end
                    SC_F2: begin
                        r_kstart2 <= w_pressed;
                        r_kcoin2  <= w_pressed;
                    end
                    default: ;
                endcase
                case (ps2_key[8:0])
                    SC_START1:   r_kstart1  <= w_pressed;
                    SC_START2:   r_kstart2  <= w_pressed;
                    SC_COIN1:    r_kcoin1   <= w_pressed;
                    SC_COIN2:    r_kcoin2   <= w_pressed;
                    SC_P2_UP:    r_k2.up    <= w_pressed;
                    SC_P2_DOWN:  r_k2.down  <= w_pressed;
                    SC_P2_LEFT:  r_k2.left  <= w_pressed;
                    SC_P2_RIGHT: r_k2.right <= w_pressed;
                    SC_P2_TRIG1: r_k2.trig1 <= w_pressed;
                    SC_P2_TRIG2: r_k2.trig2 <= w_pressed;
                    SC_P2_TRIG3: r_k2.trig3 <= w_pressed;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_joy1     <= '0;
            r_joy2     <= '0;
            r_m_coin_q <= 1'b0;
        end else begin
            r_joy1     <= joystk1[JOY_USED_W-1:0];
            r_joy2     <= joystk2[JOY_USED_W-1:0];
            r_m_coin_q <= w_m_coin;
        end
    end

    // Upright cabinets let player 2's controls also drive player 1
    assign w_p2       = r_k2 | joy_ctl(r_joy2);
    assign w_p1       = r_k1 | joy_ctl(r_joy1) | ((CABINET != 0) ? ctl_t'('0) : w_p2);
    assign w_start1   = r_kstart1 | r_joy1[JOY_START1] | r_joy2[JOY_START1];
    assign w_start2   = r_kstart2 | r_joy1[JOY_START2] | r_joy2[JOY_START2];
    assign w_m_coin   = r_kcoin1 | r_kcoin2 | r_joy1[JOY_COIN] | r_joy2[JOY_COIN];
    assign w_coin_req = w_m_coin & ~r_m_coin_q;

    sys1_coin_shaper #(
        .COIN_FRAMES (COIN_FRAMES),
        .GAP_FRAMES  (GAP_FRAMES)
    ) u_coin (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_coin_req (w_coin_req),
        .i_vblank   (vblank),
        .o_coin     (w_coin)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_inp0 <= 8'hFF;
            r_inp1 <= 8'hFF;
            r_inp2 <= 8'hFF;
        end else begin
            r_inp0 <= ctl_byte(w_p1);
            r_inp1 <= ctl_byte(w_p2);
            r_inp2 <= ~{2'b00, w_start2, w_start1, 3'b000, w_coin};
        end
    end

    assign INP0 = r_inp0;
    assign INP1 = r_inp1;
    assign INP2 = r_inp2;

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Directed bench for sys1_input_ctrl: table vectors for key/joystick merge
// on both cabinet variants, then hand-written coin pulse/queue/reset sequences.
module tb_sys1_input_ctrl;

    logic        clk_sys;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystk1;
    logic [15:0] joystk2;
    logic        vblank;
    logic [7:0]  inp0_a, inp1_a, inp2_a;
    logic [7:0]  inp0_b, inp1_b, inp2_b;
    logic        tog;

    int n_checks;
    int n_errors;

    sys1_input_ctrl #(.COIN_FRAMES(3), .GAP_FRAMES(2), .CABINET(0)) dut0 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .joystk1 (joystk1),
        .joystk2 (joystk2),
        .vblank  (vblank),
        .INP0    (inp0_a),
        .INP1    (inp1_a),
        .INP2    (inp2_a)
    );

    sys1_input_ctrl #(.COIN_FRAMES(3), .GAP_FRAMES(2), .CABINET(1)) dut1 (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .joystk1 (joystk1),
        .joystk2 (joystk2),
        .vblank  (vblank),
        .INP0    (inp0_b),
        .INP1    (inp1_b),
        .INP2    (inp2_b)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        kv;
        logic        kp;
        logic [8:0]  kc;
        logic [15:0] j1;
        logic [15:0] j2;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [7:0]  c0;
        logic [7:0]  c1;
    } vec_t;

    localparam int unsigned NVEC = 17;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%02h exp=%02h", name, act, exp);
        end
    endtask

    task automatic key_ev(input logic pressed, input logic [8:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, code};
        tick();
    endtask

    task automatic coin_tap();
        key_ev(1'b1, 9'h02E);
        key_ev(1'b0, 9'h02E);
    endtask

    // One video frame: a single-cycle vblank rise followed by a settle window
    task automatic frame();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        tog      = 1'b1;
        ps2_key  = {1'b1, 10'h000};
        joystk1  = 16'h0000;
        joystk2  = 16'h0000;
        vblank   = 1'b0;

        //                kv    kp    kc       j1        j2        e0     e1     e2     c0     c1
        vecs[0]  = '{1'b1, 1'b1, 9'h175, 16'h0000, 16'h0000, 8'hDF, 8'hFF, 8'hFF, 8'hDF, 8'hFF};
        vecs[1]  = '{1'b1, 1'b0, 9'h175, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[2]  = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0010, 8'hFD, 8'hFD, 8'hFF, 8'hFF, 8'hFD};
        vecs[3]  = '{1'b0, 1'b0, 9'h000, 16'h0001, 16'h0000, 8'hBF, 8'hFF, 8'hFF, 8'hBF, 8'hFF};
        vecs[4]  = '{1'b1, 1'b1, 9'h023, 16'h0000, 16'h0000, 8'h7F, 8'h7F, 8'hFF, 8'hFF, 8'h7F};
        vecs[5]  = '{1'b1, 1'b0, 9'h023, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[6]  = '{1'b1, 1'b1, 9'h016, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF};
        vecs[7]  = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0100, 8'hFF, 8'hFF, 8'hCF, 8'hFF, 8'hFF};
        vecs[8]  = '{1'b1, 1'b0, 9'h016, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[9]  = '{1'b1, 1'b1, 9'h029, 16'h0040, 16'h0000, 8'hFC, 8'hFF, 8'hFF, 8'hFC, 8'hFF};
        vecs[10] = '{1'b1, 1'b0, 9'h129, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[11] = '{1'b1, 1'b1, 9'h123, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vecs[12] = '{1'b0, 1'b0, 9'h000, 16'h000C, 16'h0000, 8'hCF, 8'hFF, 8'hFF, 8'hCF, 8'hFF};
        vecs[13] = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0080, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF};
        vecs[14] = '{1'b0, 1'b0, 9'h000, 16'h0000, 16'h0020, 8'hFB, 8'hFB, 8'hFF, 8'hFF, 8'hFB};
        vecs[15] = '{1'b1, 1'b1, 9'h015, 16'h0000, 16'h0000, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFE};
        vecs[16] = '{1'b1, 1'b0, 9'h015, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Reset, released with the toggle bit high: no spurious key
        repeat (3) tick();
        chk("rst_inp0", inp0_a, 8'hFF);
        chk("rst_inp2", inp2_a, 8'hFF);
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_inp0_cab0", inp0_a, 8'hFF);
        chk("post_rst_inp1_cab0", inp1_a, 8'hFF);
        chk("post_rst_inp2_cab0", inp2_a, 8'hFF);
        chk("post_rst_inp0_cab1", inp0_b, 8'hFF);
        chk("post_rst_inp1_cab1", inp1_b, 8'hFF);
        chk("post_rst_inp2_cab1", inp2_b, 8'hFF);

        // Joystick-to-INP latency is exactly two clocks
        joystk1 = 16'h0008;
        tick();
        chk("lat_1clk", inp0_a, 8'hFF);
        tick();
        chk("lat_2clk", inp0_a, 8'hDF);
        joystk1 = 16'h0000;
        repeat (2) tick();
        chk("lat_clear", inp0_a, 8'hFF);

        // Same for a PS/2 toggle
        tog     = ~tog;
        ps2_key = {tog, 1'b1, 9'h06B};
        tick();
        chk("ps2_lat_1clk", inp0_a, 8'hFF);
        tick();
        chk("ps2_lat_2clk", inp0_a, 8'h7F);
        key_ev(1'b0, 9'h06B);
        tick();
        chk("ps2_release", inp0_a, 8'hFF);

        for (int i = 0; i < int'(NVEC); i++) begin
            if (vecs[i].kv) begin
                tog     = ~tog;
                ps2_key = {tog, vecs[i].kp, vecs[i].kc};
            end
            joystk1 = vecs[i].j1;
            joystk2 = vecs[i].j2;
            repeat (2) tick();
            chk($sformatf("vec%0d_inp0_cab0", i), inp0_a, vecs[i].e0);
            chk($sformatf("vec%0d_inp1_cab0", i), inp1_a, vecs[i].e1);
            chk($sformatf("vec%0d_inp2_cab0", i), inp2_a, vecs[i].e2);
            chk($sformatf("vec%0d_inp0_cab1", i), inp0_b, vecs[i].c0);
            chk($sformatf("vec%0d_inp1_cab1", i), inp1_b, vecs[i].c1);
            chk($sformatf("vec%0d_inp2_cab1", i), inp2_b, vecs[i].e2);
        end
        joystk1 = 16'h0000;
        joystk2 = 16'h0000;
        repeat (4) tick();

        // Single coin with the key held through the pulse
        key_ev(1'b1, 9'h02E);
        repeat (4) tick();
        chk("coin_start", inp2_a, 8'hFE);
        frame();
        chk("coin_f1", inp2_a, 8'hFE);
        frame();
        chk("coin_f2", inp2_a, 8'hFE);
        frame();
        chk("coin_f3_end", inp2_a, 8'hFF);
        key_ev(1'b0, 9'h02E);
        coin_tap();
        repeat (2) tick();
        chk("gap_blocks", inp2_a, 8'hFF);
        frame();
        chk("gap_f1", inp2_a, 8'hFF);
        frame();
        chk("second_coin_start", inp2_a, 8'hFE);
        frame();
        frame();
        chk("second_coin_f2", inp2_a, 8'hFE);
        frame();
        chk("second_coin_end", inp2_a, 8'hFF);
        repeat (3) frame();
        chk("single_idle", inp2_a, 8'hFF);
        chk("single_queue", 8'(dut0.u_coin.r_queue), 8'h00);

        // Coin in progress, then five quick presses: three queue, two drop
        coin_tap();
        repeat (4) tick();
        for (int i = 0; i < 5; i++) coin_tap();
        chk("queue_full", 8'(dut0.u_coin.r_queue), 8'h03);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("q_pulse%0d_on", p), inp2_a, 8'hFE);
            frame();
            chk($sformatf("q_pulse%0d_f1", p), inp2_a, 8'hFE);
            frame();
            chk($sformatf("q_pulse%0d_f2", p), inp2_a, 8'hFE);
            frame();
            chk($sformatf("q_pulse%0d_off", p), inp2_a, 8'hFF);
            frame();
            chk($sformatf("q_gap%0d", p), inp2_a, 8'hFF);
            frame();
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("q_idle%0d", i), inp2_a, 8'hFF);
            frame();
        end
        chk("queue_empty", 8'(dut0.u_coin.r_queue), 8'h00);

        // Reset mid-pulse with one coin pending
        coin_tap();
        repeat (4) tick();
        chk("rst_pulse_on", inp2_a, 8'hFE);
        coin_tap();
        chk("rst_pending", 8'(dut0.u_coin.r_queue), 8'h01);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_inp2", inp2_a, 8'hFF);
        chk("rst_queue_clear", 8'(dut0.u_coin.r_queue), 8'h00);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            frame();
            chk($sformatf("rst_no_pulse%0d", i), inp2_a, 8'hFF);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
